// File: rtl/periph_bus_pkg.sv
// Shared constants for the peripheral bus controller: state encoding and address widths.
package periph_bus_pkg;

  localparam int SLOT_AW = 4;
  localparam int REG_AW  = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;
  localparam state_t ST_ERR    = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/periph_bus_timeout.sv
// Wait-cycle counter for a peripheral access; expired fires on the cycle the limit is hit.
module periph_bus_timeout
  import periph_bus_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Combinational so the move to ERR happens on the edge that would make the count reach TIMEOUT.
  assign expired = enable && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/periph_bus_controller.sv
// Single-master controller sequencing one access at a time to a set of peripheral slots.
module periph_bus_controller
  import periph_bus_pkg::*;
#(
  parameter int                    NUM_PERIPH = 4,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    TIMEOUT    = 15,
  parameter logic [NUM_PERIPH-1:0] SLOT_EN    = '1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [SLOT_AW-1:0]               periph_address,
  input  logic [REG_AW-1:0]                reg_address,
  input  logic                             rw,
  input  logic                             ce,
  input  logic [DATA_WIDTH-1:0]            data_in,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             ready,
  output logic                             bus_err,
  output logic [NUM_PERIPH-1:0]            p_ce,
  output logic                             p_rw,
  output logic [REG_AW-1:0]                p_reg_address,
  output logic [DATA_WIDTH-1:0]            p_wdata,
  input  logic [NUM_PERIPH*DATA_WIDTH-1:0] p_rdata,
  input  logic [NUM_PERIPH-1:0]            p_ready,
  output logic [7:0]                       err_count,
  output logic [7:0]                       err_addr
);

  state_t                  state, state_n;
  logic [SLOT_AW-1:0]      sel_q;
  logic [REG_AW-1:0]       reg_q;
  logic                    rw_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic [DATA_WIDTH-1:0]   rdata_sel;
  logic                    ready_sel;
  logic                    slot_ok;
  logic                    in_access;
  logic                    tmo_clear;
  logic                    tmo_expired;
  logic                    err_enter;
  logic                    err_rd;
  logic [7:0]              err_addr_n;

  assign in_access = (state == ST_ACCESS);

  // Slot decode done as a compare loop so no out-of-range part-select is ever formed.
  always_comb begin
    rdata_sel = '0;
    ready_sel = 1'b0;
    p_ce      = '0;
    slot_ok   = 1'b0;
    for (int unsigned k = 0; k < NUM_PERIPH; k++) begin
      if (sel_q == SLOT_AW'(k)) begin
        rdata_sel = p_rdata[k*DATA_WIDTH +: DATA_WIDTH];
        ready_sel = p_ready[k];
        p_ce[k]   = in_access;
      end
      if (periph_address == SLOT_AW'(k)) begin
        slot_ok = SLOT_EN[k];
      end
    end
  end

  assign p_rw          = in_access & rw_q;
  assign p_reg_address = in_access ? reg_q : '0;
  assign p_wdata       = in_access ? wdata_q : '0;
  assign ready         = (state == ST_RESP) || (state == ST_ERR);
  assign bus_err       = (state == ST_ERR);

  periph_bus_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (in_access && !ready_sel),
    .expired(tmo_expired)
  );

  always_comb begin
    state_n    = state;
    tmo_clear  = 1'b0;
    err_enter  = 1'b0;
    err_rd     = !rw_q;
    err_addr_n = {sel_q, reg_q};
    case (state)
      ST_IDLE: begin
        // Decode errors are flagged before the latches load, so use the live inputs.
        err_rd     = !rw;
        err_addr_n = {periph_address, reg_address};
        if (ce) begin
          tmo_clear = 1'b1;
          state_n   = slot_ok ? ST_ACCESS : ST_ERR;
          err_enter = !slot_ok;
        end
      end
      ST_ACCESS: begin
        if (ready_sel) begin
          state_n = ST_RESP;
        end else if (tmo_expired) begin
          state_n   = ST_ERR;
          err_enter = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      reg_q     <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      data_out  <= '0;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && ce) begin
        sel_q   <= periph_address;
        reg_q   <= reg_address;
        rw_q    <= rw;
        wdata_q <= data_in;
      end
      if (in_access && ready_sel && !rw_q) begin
        data_out <= rdata_sel;
      end
      // Error bookkeeping lands on entry to ERR so it is valid alongside the ready pulse.
      if (err_enter) begin
        err_count <= sat_inc8(err_count);
        err_addr  <= err_addr_n;
        if (err_rd) begin
          data_out <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_periph_bus_controller.sv
// Randomized self-checking bench for periph_bus_controller with a transaction-level reference model.
module tb_periph_bus_controller;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TO = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        periph_address = '0;
  logic [3:0]        reg_address = '0;
  logic              rw = 1'b0;
  logic              ce = 1'b0;
  logic [DW-1:0]     data_in = '0;
  logic [DW-1:0]     data_out;
  logic              ready;
  logic              bus_err;
  logic [NP-1:0]     p_ce;
  logic              p_rw;
  logic [3:0]        p_reg_address;
  logic [DW-1:0]     p_wdata;
  logic [NP*DW-1:0]  p_rdata = '0;
  logic [NP-1:0]     p_ready = '0;
  logic [7:0]        err_count;
  logic [7:0]        err_addr;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DW-1:0] exp_data = '0;
  int            exp_err_count = 0;
  logic [7:0]    exp_err_addr = '0;

  periph_bus_controller #(
    .NUM_PERIPH(NP),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .periph_address(periph_address),
    .reg_address   (reg_address),
    .rw            (rw),
    .ce            (ce),
    .data_in       (data_in),
    .data_out      (data_out),
    .ready         (ready),
    .bus_err       (bus_err),
    .p_ce          (p_ce),
    .p_rw          (p_rw),
    .p_reg_address (p_reg_address),
    .p_wdata       (p_wdata),
    .p_rdata       (p_rdata),
    .p_ready       (p_ready),
    .err_count     (err_count),
    .err_addr      (err_addr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction: d = wait cycles before the addressed slot acks (d >= TO never acks in time).
  task automatic run_txn(input logic [3:0] pa, input logic [3:0] ra, input logic wr,
                         input logic [DW-1:0] wd, input int unsigned d, input logic [DW-1:0] rd);
    bit            valid, done, is_err;
    int            s, cyc, pce_cycles, exp_lat, exp_pce;
    logic [NP-1:0] onehot;
    s      = int'(pa);
    valid  = (s < NP);
    onehot = '0;
    if (valid) onehot[s] = 1'b1;

    @(negedge clk);
    periph_address = pa; reg_address = ra; rw = wr; data_in = wd; ce = 1'b1;
    for (int k = 0; k < NP; k++) p_rdata[k*DW +: DW] = $urandom;
    if (valid) p_rdata[s*DW +: DW] = rd;
    p_ready = NP'($urandom);
    if (valid) p_ready[s] = 1'b0;
    @(posedge clk);

    if (!valid) begin
      exp_lat = 1; exp_pce = 0; is_err = 1'b1;
    end else if (d < TO) begin
      exp_lat = int'(d) + 2; exp_pce = int'(d) + 1; is_err = 1'b0;
    end else begin
      exp_lat = TO + 1; exp_pce = TO; is_err = 1'b1;
    end

    cyc = 0; done = 1'b0; pce_cycles = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ready) begin
        done = 1'b1;
      end else begin
        if (p_ce != '0) begin
          pce_cycles++;
          check_val("p_ce_onehot", 64'(p_ce), 64'(onehot));
          check_val("p_bus", {p_rw, p_reg_address, p_wdata}, {wr, ra, wd});
        end
        // Inputs wander during the access; the latched request must be unaffected.
        ce = 1'($urandom); periph_address = 4'($urandom); reg_address = 4'($urandom);
        rw = 1'($urandom); data_in = $urandom;
        p_ready = NP'($urandom);
        if (valid) p_ready[s] = (cyc == int'(d) + 1);
      end
    end
    ce = 1'b0;
    p_ready = '0;

    if (is_err) begin
      exp_err_count = (exp_err_count < 255) ? exp_err_count + 1 : 255;
      exp_err_addr  = {pa, ra};
      if (!wr) exp_data = '0;
    end else if (!wr) begin
      exp_data = rd;
    end

    if (!done) begin
      check_val("ready_timeout", 64'(0), 64'(1));
    end else begin
      check_val("latency", 64'(cyc), 64'(exp_lat));
      check_val("bus_err", 64'(bus_err), 64'(is_err));
      check_val("p_ce_cycles", 64'(pce_cycles), 64'(exp_pce));
      check_val("p_ce_at_ready", 64'(p_ce), 64'(0));
      check_val("data_out", 64'(data_out), 64'(exp_data));
      check_val("err_count", 64'(err_count), 64'(exp_err_count));
      check_val("err_addr", 64'(err_addr), 64'(exp_err_addr));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int             rdy_cyc[2];
    logic [DW-1:0]  rdy_dat[2];
    logic           rdy_err[2];
    int             n_rdy;
    logic [3:0]     pa;

    #1;
    check_val("rst_data_out", 64'(data_out), 64'(0));
    check_val("rst_ctrl", {ready, bus_err, p_ce, p_rw, p_reg_address}, 64'(0));
    check_val("rst_wdata", 64'(p_wdata), 64'(0));
    check_val("rst_err", {err_count, err_addr}, 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed cases
    run_txn(4'd1, 4'd2, 1'b0, 32'h0, 0, 32'hCAFE_0001);
    run_txn(4'd0, 4'd5, 1'b1, 32'h0000_00A5, 3, 32'h0);
    run_txn(4'd7, 4'd3, 1'b0, 32'h0, 0, 32'h0);
    run_txn(4'd2, 4'd1, 1'b0, 32'h0, 100, 32'h0);
    run_txn(4'd2, 4'd1, 1'b0, 32'h0, TO - 1, 32'h1234_5678);
    run_txn(4'd3, 4'd0, 1'b1, 32'hDEAD_BEEF, TO, 32'h0);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      pa = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      run_txn(pa, 4'($urandom), 1'($urandom), $urandom, $urandom_range(0, 18), $urandom);
    end

    // ce held high across two reads
    @(negedge clk);
    periph_address = 4'd0; reg_address = 4'd1; rw = 1'b0; ce = 1'b1;
    p_rdata[0*DW +: DW] = 32'h1111_0000;
    p_rdata[3*DW +: DW] = 32'h3333_0003;
    p_ready = '0;
    @(posedge clk);
    n_rdy = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (ready && n_rdy < 2) begin
        rdy_cyc[n_rdy] = cyc; rdy_dat[n_rdy] = data_out; rdy_err[n_rdy] = bus_err;
        n_rdy++;
      end
      if (cyc == 1) periph_address = 4'd3;
      if (cyc == 4) ce = 1'b0;
      p_ready = p_ce;
    end
    p_ready = '0;
    check_val("b2b_count", 64'(n_rdy), 64'(2));
    if (n_rdy == 2) begin
      check_val("b2b_first", 64'(rdy_cyc[0]), 64'(2));
      check_val("b2b_gap", 64'(rdy_cyc[1] - rdy_cyc[0]), 64'(3));
      check_val("b2b_data0", 64'(rdy_dat[0]), 64'h1111_0000);
      check_val("b2b_data1", 64'(rdy_dat[1]), 64'h3333_0003);
      check_val("b2b_err", 64'({rdy_err[0], rdy_err[1]}), 64'(0));
    end
    exp_data = 32'h3333_0003;

    // Saturate the error counter
    for (int i = 0; i < 260; i++) begin
      run_txn(4'($urandom_range(4, 15)), 4'($urandom), 1'($urandom), $urandom, 0, 32'h0);
    end
    check_val("err_saturated", 64'(err_count), 64'(255));

    // Reset in the middle of an access
    @(negedge clk);
    periph_address = 4'd2; reg_address = 4'd4; rw = 1'b0; ce = 1'b1; p_ready = '0;
    @(posedge clk);
    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
    check_val("pre_rst_p_ce", 64'(p_ce), 64'(4'b0100));
    #1 rst = 1'b0;
    #1;
    check_val("async_p_ce", 64'(p_ce), 64'(0));
    check_val("async_ready", 64'(ready), 64'(0));
    check_val("async_regs", {err_count, err_addr, data_out}, 64'(0));
    @(negedge clk);
    rst = 1'b1;
    n_rdy = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (ready) n_rdy++;
      p_ready = p_ce;
    end
    p_ready = '0;
    check_val("no_ready_after_rst", 64'(n_rdy), 64'(0));
    exp_data = '0; exp_err_count = 0; exp_err_addr = '0;

    run_txn(4'd1, 4'd9, 1'b0, 32'h0, 2, 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/periph_bus_controller.md
PERIPH_BUS_CONTROLLER -- requirements
Module: periph_bus_controller

Interface
REQ-001 SHALL have parameter NUM_PERIPH, default 4, number of peripheral slots (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max cycles waiting for p_ready (1..255).
REQ-004 SHALL have parameter SLOT_EN, default all-ones [NUM_PERIPH-1:0], per-slot mapped mask.
REQ-005 SHALL have ports: clk  in  1  single clock, rising edge; rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: periph_address  in  4  slot select; reg_address  in  4  register within slot; rw  in  1  1=write 0=read; ce  in  1  access request.
REQ-007 SHALL have ports: data_in  in  DATA_WIDTH  write data; data_out  out  DATA_WIDTH  registered read data; ready  out  1  one-cycle completion strobe; bus_err  out  1  error flag, valid with ready.
REQ-008 SHALL have ports: p_ce  out  NUM_PERIPH  one-hot slot enable; p_rw  out  1; p_reg_address  out  4; p_wdata  out  DATA_WIDTH.
REQ-009 SHALL have ports: p_rdata  in  NUM_PERIPH*DATA_WIDTH  flattened read data, slot k at [k*DATA_WIDTH +: DATA_WIDTH]; p_ready  in  NUM_PERIPH  per-slot ack.
REQ-010 SHALL have ports: err_count  out  8  saturating error count; err_addr  out  8  {periph_address, reg_address} of last error.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, RESP, ERR.
REQ-012 IDLE: on ce=1, SHALL latch periph_address, reg_address, rw, data_in into internal registers.
REQ-013 IDLE: on ce=1, SHALL go ERR if periph_address>=NUM_PERIPH or SLOT_EN[periph_address]=0, else ACCESS.
REQ-014 ACCESS: SHALL drive p_ce one-hot for the latched slot, p_rw/p_reg_address/p_wdata from latches; all p_ce zero in every other state.
REQ-015 ACCESS: wait counter SHALL clear on entry and increment each cycle p_ready[sel]=0.
REQ-016 ACCESS: p_ready[sel]=1 SHALL move to RESP; on a read, data_out SHALL load the slot's p_rdata that cycle.
REQ-017 ACCESS: counter reaching TIMEOUT with p_ready[sel]=0 SHALL move to ERR; p_ready in the same cycle SHALL take priority over timeout.
REQ-018 p_ready of non-selected slots SHALL be ignored.
REQ-019 RESP: ready=1, bus_err=0 for exactly one cycle, then IDLE.
REQ-020 ERR: ready=1, bus_err=1 for exactly one cycle, then IDLE.
REQ-021 ERR: err_count SHALL increment, saturating at 255; err_addr SHALL load the latched address.
REQ-022 ERR on a read: data_out SHALL load 0.
REQ-023 Writes SHALL leave data_out unchanged.
REQ-024 ce SHALL be sampled only in IDLE; ce changes during ACCESS/RESP/ERR SHALL not abort or alter the transaction.
REQ-025 Min latency ce-sample to ready SHALL be 2 cycles (p_ready in first ACCESS cycle); timeout latency SHALL be TIMEOUT+1 cycles.
REQ-026 ce held high after ready SHALL start a new transaction on the first IDLE cycle (back-to-back at 3-cycle throughput).

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, clear latches and wait counter, and zero data_out, ready, bus_err, p_ce, p_rw, p_reg_address, p_wdata, err_count, err_addr.
REQ-028 Reset mid-ACCESS SHALL drop p_ce the same instant and produce no ready pulse after release.

Structure
REQ-029 State encoding and slot-address width constant SHALL live in shared package periph_bus_pkg.
REQ-030 The wait counter with timeout compare SHALL be sub-module periph_bus_timeout (inputs clear/enable, output expired).

Verification
REQ-031 Read slot 1, reg 2; slot 1 returns 32'hCAFE_0001 with p_ready in first ACCESS cycle -> p_ce=4'b0010 for 1 cycle, ready 2 cycles after ce sample, data_out=32'hCAFE_0001, bus_err=0.
REQ-032 Write 32'h0000_00A5 to slot 0, p_ready after 3 wait cycles -> p_wdata=32'hA5, p_rw=1 held 4 cycles, ready once, data_out unchanged.
REQ-033 Read periph_address=4'h7 with NUM_PERIPH=4 -> no p_ce, ready+bus_err next cycle, data_out=0, err_count=1, err_addr=8'h7x.
REQ-034 Slot 2 never asserts p_ready, TIMEOUT=15 -> ready+bus_err 16 cycles after ce sample; p_ready on cycle 15 instead -> normal RESP, bus_err=0.
REQ-035 256 consecutive errors -> err_count=255 saturated; rst=0 during ACCESS -> p_ce=0 immediately, no ready after release.
REQ-036 ce held high across two reads (slots 0 then 3) -> both complete, ready pulses 3 cycles apart, data per slot correct.
